lock_reg_frontend: RTL and testbench

Bus-facing front end for the lockable data registers of the CWE-1234 block family. It accepts single-beat write requests over a valid/ready handshake and decodes them into the downstream stage's `write` strobe with registered data, a `Lock` pulse, and the `debug_unlocked` qualifier. `debug_unlocked` is produced by a key-authenticated debug FSM with an attempt limit, a lockout penalty and a session timeout. The block sits directly upstream of the lockable data-out registers and drives their `write`, `Lock`, `debug_unlocked` and data inputs.

---
 rtl/lock_reg_frontend.sv | 112 +++++++++++
 tb/tb_lock_reg_frontend.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/lock_reg_frontend.sv
// lock_reg_frontend: valid/ready front end driving write/Lock/data of lockable registers, with key-gated debug unlock.
// Optional feature macro: LOCK_REG_DEBUG_UNLOCK_EN (debug FSM, timers, addr 2/3 handling).
module lock_reg_frontend #(
  parameter int          KEY_W          = 32,
  parameter logic [31:0] KEY_VALUE      = 32'hC0DE_1234,
  parameter int          MAX_TRIES      = 3,
  parameter int          PENALTY_CYCLES = 1024,
  parameter int          SESSION_CYCLES = 65535
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_addr,
  input  logic [31:0] req_data,
  output logic        write,
  output logic [31:0] Data_in_32bit,
  output logic        Lock,
  output logic        debug_unlocked,
  output logic        lockout,
  output logic [3:0]  fail_count,
  output logic        err
);
  logic acc;
  assign acc = req_valid & req_ready;
  if (KEY_W < 1 || KEY_W > 32 || MAX_TRIES < 1 || MAX_TRIES > 15 || PENALTY_CYCLES < 1 ||
      SESSION_CYCLES < 1 || (KEY_VALUE >> KEY_W) != 32'd0) begin : g_bad_params
    $error("lock_reg_frontend: parameter out of range");
  end
  always_ff @(posedge Clk) begin
    if (reset) begin
      write         <= 1'b0;
      Lock          <= 1'b0;
      Data_in_32bit <= '0;
    end else begin
      write <= acc && req_addr == 2'd0;
      Lock  <= acc && req_addr == 2'd1 && req_data[0];
      if (acc && req_addr == 2'd0) Data_in_32bit <= req_data;
    end
  end
`ifdef LOCK_REG_DEBUG_UNLOCK_EN
  localparam int TM = PENALTY_CYCLES > SESSION_CYCLES ? PENALTY_CYCLES : SESSION_CYCLES;
  localparam int TW = $clog2(TM + 1);
  typedef enum logic [1:0] {LOCKED, CHECK, UNLOCKED, PENALTY} state_t;
  state_t            state, state_n;
  logic [TW-1:0]     timer, timer_n;
  logic [KEY_W-1:0]  key, key_n;
  logic [3:0]        fail_n;
  logic              err_n;
  assign req_ready      = state != CHECK;
  assign debug_unlocked = state == UNLOCKED;
  assign lockout        = state == PENALTY;
  always_ff @(posedge Clk) begin
    if (reset) begin
      state      <= LOCKED;
      timer      <= '0;
      key        <= '0;
      fail_count <= '0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      key        <= key_n;
      fail_count <= fail_n;
      err        <= err_n;
    end
  end
  // Session and penalty never overlap, so one down-counter serves both.
  always_comb begin
    state_n = state;
    timer_n = timer;
    key_n   = key;
    fail_n  = fail_count;
    err_n   = 1'b0;
    case (state)
      LOCKED: if (acc && req_addr == 2'd2) begin
        key_n   = req_data[KEY_W-1:0];
        state_n = CHECK;
      end
      CHECK: if (key == KEY_VALUE[KEY_W-1:0]) begin
        state_n = UNLOCKED;
        fail_n  = '0;
        timer_n = TW'(SESSION_CYCLES - 1);
      end else if (fail_count + 4'd1 == 4'(MAX_TRIES)) begin
        state_n = PENALTY;
        fail_n  = 4'(MAX_TRIES);
        timer_n = TW'(PENALTY_CYCLES - 1);
      end else begin
        state_n = LOCKED;
        fail_n  = fail_count + 4'd1;
      end
      UNLOCKED: if ((acc && req_addr == 2'd3) || timer == '0) begin
        state_n = LOCKED;
        timer_n = '0;
      end else timer_n = timer - 1'b1;
      PENALTY: begin
        err_n = acc && req_addr == 2'd2;
        if (timer == '0) begin
          state_n = LOCKED;
          fail_n  = '0;
        end else timer_n = timer - 1'b1;
      end
    endcase
  end
`else
  assign req_ready      = 1'b1;
  assign debug_unlocked = 1'b0;
  assign lockout        = 1'b0;
  assign fail_count     = '0;
  always_ff @(posedge Clk) err <= reset ? 1'b0 : acc && req_addr[1];
`endif
endmodule

// File: tb/tb_lock_reg_frontend.sv
// tb_lock_reg_frontend: directed checks of the front end; debug-FSM tests run when LOCK_REG_DEBUG_UNLOCK_EN is defined.
module tb_lock_reg_frontend;
  localparam logic [31:0] KEY = 32'hC0DE_1234;
  logic        Clk = 1'b0, reset = 1'b1, req_valid = 1'b0, req_ready;
  logic [1:0]  req_addr = '0;
  logic [31:0] req_data = '0, Data_in_32bit;
  logic        write, Lock, debug_unlocked, lockout, err;
  logic [3:0]  fail_count;
  int n_cmp = 0, n_bad = 0;
  lock_reg_frontend #(.MAX_TRIES(3), .PENALTY_CYCLES(8), .SESSION_CYCLES(16)) dut (
    .Clk(Clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_data(req_data), .write(write), .Data_in_32bit(Data_in_32bit), .Lock(Lock),
    .debug_unlocked(debug_unlocked), .lockout(lockout), .fail_count(fail_count), .err(err));
  always #5 Clk = ~Clk;
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask
  task automatic send(input logic [1:0] a, input logic [31:0] d);
    int g = 0;
    req_valid = 1'b1; req_addr = a; req_data = d;
    while (!req_ready && g < 10) begin tick(); g++; end
    n_cmp++; if (!req_ready) begin n_bad++; $display("FAIL send_ready: got ready=%b required 1", req_ready); end
    tick();
    req_valid = 1'b0;
  endtask
  task automatic test_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    n_cmp++; if (write !== 1'b0) begin n_bad++; $display("FAIL rst_write: got %b required 0", write); end
    n_cmp++; if (Lock !== 1'b0) begin n_bad++; $display("FAIL rst_lock: got %b required 0", Lock); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b required 0", err); end
    n_cmp++; if (debug_unlocked !== 1'b0) begin n_bad++; $display("FAIL rst_du: got %b required 0", debug_unlocked); end
    n_cmp++; if (lockout !== 1'b0) begin n_bad++; $display("FAIL rst_lockout: got %b required 0", lockout); end
    n_cmp++; if (Data_in_32bit !== 32'h0) begin n_bad++; $display("FAIL rst_data: got %h required 0", Data_in_32bit); end
    n_cmp++; if (fail_count !== 4'd0) begin n_bad++; $display("FAIL rst_fail: got %0d required 0", fail_count); end
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b required 1", req_ready); end
  endtask
  task automatic test_data_write();
    send(2'd0, 32'hA5A5_5A5A);
    n_cmp++; if (write !== 1'b1) begin n_bad++; $display("FAIL dw_write: got %b required 1", write); end
    n_cmp++; if (Data_in_32bit !== 32'hA5A5_5A5A) begin n_bad++; $display("FAIL dw_data: got %h required a5a55a5a", Data_in_32bit); end
    n_cmp++; if (Lock !== 1'b0) begin n_bad++; $display("FAIL dw_lock: got %b required 0", Lock); end
    n_cmp++; if (debug_unlocked !== 1'b0) begin n_bad++; $display("FAIL dw_du: got %b required 0", debug_unlocked); end
    tick();
    n_cmp++; if (write !== 1'b0) begin n_bad++; $display("FAIL dw_write_end: got %b required 0", write); end
    n_cmp++; if (Data_in_32bit !== 32'hA5A5_5A5A) begin n_bad++; $display("FAIL dw_data_hold: got %h required a5a55a5a", Data_in_32bit); end
  endtask
  task automatic test_lock_cmd();
    send(2'd1, 32'h1);
    n_cmp++; if (Lock !== 1'b1) begin n_bad++; $display("FAIL lk_pulse: got %b required 1", Lock); end
    n_cmp++; if (write !== 1'b0) begin n_bad++; $display("FAIL lk_write: got %b required 0", write); end
    tick();
    n_cmp++; if (Lock !== 1'b0) begin n_bad++; $display("FAIL lk_end: got %b required 0", Lock); end
    send(2'd1, 32'hFFFF_FFFE);
    n_cmp++; if (Lock !== 1'b0) begin n_bad++; $display("FAIL lk_data0: got %b required 0", Lock); end
  endtask
  task automatic test_back_to_back();
    req_valid = 1'b1; req_addr = 2'd0; req_data = 32'h0000_0011;
    tick();
    n_cmp++; if (write !== 1'b1 || Data_in_32bit !== 32'h11) begin n_bad++; $display("FAIL b2b_1: got w=%b d=%h required w=1 d=00000011", write, Data_in_32bit); end
    req_data = 32'h2200_0000;
    tick();
    n_cmp++; if (write !== 1'b1 || Data_in_32bit !== 32'h2200_0000) begin n_bad++; $display("FAIL b2b_2: got w=%b d=%h required w=1 d=22000000", write, Data_in_32bit); end
    req_valid = 1'b0;
    tick();
    n_cmp++; if (write !== 1'b0) begin n_bad++; $display("FAIL b2b_end: got %b required 0", write); end
  endtask
`ifdef LOCK_REG_DEBUG_UNLOCK_EN
  task automatic test_good_key();
    int cnt, g;
    send(2'd2, KEY);
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL gk_check_ready: got %b required 0", req_ready); end
    n_cmp++; if (debug_unlocked !== 1'b0) begin n_bad++; $display("FAIL gk_check_du: got %b required 0", debug_unlocked); end
    tick();
    n_cmp++; if (debug_unlocked !== 1'b1 || req_ready !== 1'b1) begin n_bad++; $display("FAIL gk_unlock: got du=%b ready=%b required 1 1", debug_unlocked, req_ready); end
    cnt = 1; g = 0;
    while (debug_unlocked && g < 40) begin tick(); g++; if (debug_unlocked) cnt++; end
    n_cmp++; if (cnt !== 16) begin n_bad++; $display("FAIL gk_session_len: got %0d required 16", cnt); end
    send(2'd2, KEY); tick();
    send(2'd2, 32'h1);
    n_cmp++; if (err !== 1'b0 || debug_unlocked !== 1'b1 || req_ready !== 1'b1) begin n_bad++; $display("FAIL gk_key_in_session: got err=%b du=%b ready=%b required 0 1 1", err, debug_unlocked, req_ready); end
    tick(); tick();
    n_cmp++; if (debug_unlocked !== 1'b1) begin n_bad++; $display("FAIL gk_before_relock: got %b required 1", debug_unlocked); end
    send(2'd3, 32'h0);
    n_cmp++; if (debug_unlocked !== 1'b0 || fail_count !== 4'd0) begin n_bad++; $display("FAIL gk_relock: got du=%b fail=%0d required 0 0", debug_unlocked, fail_count); end
  endtask
  task automatic test_lockout();
    int cnt, g;
    send(2'd2, 32'h1); tick();
    n_cmp++; if (fail_count !== 4'd1 || lockout !== 1'b0) begin n_bad++; $display("FAIL lo_try1: got fail=%0d lockout=%b required 1 0", fail_count, lockout); end
    send(2'd2, 32'h1); tick();
    n_cmp++; if (fail_count !== 4'd2 || lockout !== 1'b0) begin n_bad++; $display("FAIL lo_try2: got fail=%0d lockout=%b required 2 0", fail_count, lockout); end
    send(2'd2, 32'h1); tick();
    n_cmp++; if (fail_count !== 4'd3 || lockout !== 1'b1) begin n_bad++; $display("FAIL lo_try3: got fail=%0d lockout=%b required 3 1", fail_count, lockout); end
    cnt = 1;
    send(2'd2, KEY);
    if (lockout) cnt++;
    n_cmp++; if (err !== 1'b1 || debug_unlocked !== 1'b0 || fail_count !== 4'd3) begin n_bad++; $display("FAIL lo_key_in_penalty: got err=%b du=%b fail=%0d required 1 0 3", err, debug_unlocked, fail_count); end
    tick();
    if (lockout) cnt++;
    n_cmp++; if (err !== 1'b0 || debug_unlocked !== 1'b0) begin n_bad++; $display("FAIL lo_err_end: got err=%b du=%b required 0 0", err, debug_unlocked); end
    g = 0;
    while (lockout && g < 40) begin tick(); g++; if (lockout) cnt++; end
    n_cmp++; if (cnt !== 8) begin n_bad++; $display("FAIL lo_penalty_len: got %0d required 8", cnt); end
    n_cmp++; if (fail_count !== 4'd0) begin n_bad++; $display("FAIL lo_fail_clear: got %0d required 0", fail_count); end
    send(2'd2, KEY); tick();
    n_cmp++; if (debug_unlocked !== 1'b1) begin n_bad++; $display("FAIL lo_unlock_after: got %b required 1", debug_unlocked); end
  endtask
  task automatic test_reset_mid();
    reset = 1'b1; tick(); reset = 1'b0;
    n_cmp++; if (debug_unlocked !== 1'b0 || fail_count !== 4'd0) begin n_bad++; $display("FAIL rm_session: got du=%b fail=%0d required 0 0", debug_unlocked, fail_count); end
    for (int i = 0; i < 3; i++) begin send(2'd2, 32'h1); tick(); end
    n_cmp++; if (lockout !== 1'b1) begin n_bad++; $display("FAIL rm_enter_penalty: got %b required 1", lockout); end
    reset = 1'b1; tick(); reset = 1'b0;
    n_cmp++; if (lockout !== 1'b0 || fail_count !== 4'd0) begin n_bad++; $display("FAIL rm_penalty: got lockout=%b fail=%0d required 0 0", lockout, fail_count); end
    send(2'd0, 32'h0BAD_F00D);
    n_cmp++; if (write !== 1'b1 || Data_in_32bit !== 32'h0BAD_F00D) begin n_bad++; $display("FAIL rm_write: got w=%b d=%h required w=1 d=0badf00d", write, Data_in_32bit); end
  endtask
`else
  task automatic test_macro_off();
    send(2'd2, KEY);
    n_cmp++; if (err !== 1'b1 || debug_unlocked !== 1'b0) begin n_bad++; $display("FAIL mo_key: got err=%b du=%b required 1 0", err, debug_unlocked); end
    n_cmp++; if (req_ready !== 1'b1 || write !== 1'b0) begin n_bad++; $display("FAIL mo_key_side: got ready=%b write=%b required 1 0", req_ready, write); end
    tick();
    n_cmp++; if (err !== 1'b0 || debug_unlocked !== 1'b0) begin n_bad++; $display("FAIL mo_after: got err=%b du=%b required 0 0", err, debug_unlocked); end
    send(2'd3, 32'h0);
    n_cmp++; if (err !== 1'b1 || Lock !== 1'b0) begin n_bad++; $display("FAIL mo_relock: got err=%b lock=%b required 1 0", err, Lock); end
    send(2'd0, 32'h1234_5678);
    n_cmp++; if (write !== 1'b1 || err !== 1'b0 || Data_in_32bit !== 32'h1234_5678) begin n_bad++; $display("FAIL mo_write: got w=%b err=%b d=%h required 1 0 12345678", write, err, Data_in_32bit); end
    n_cmp++; if (lockout !== 1'b0 || fail_count !== 4'd0) begin n_bad++; $display("FAIL mo_tied: got lockout=%b fail=%0d required 0 0", lockout, fail_count); end
  endtask
`endif
  initial begin
    test_reset();
    test_data_write();
    test_lock_cmd();
    test_back_to_back();
`ifdef LOCK_REG_DEBUG_UNLOCK_EN
    test_good_key();
    test_lockout();
    test_reset_mid();
`else
    test_macro_off();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
